// File: rtl/fracturable_lut.sv
// Purpose: configurable LUT, one full table or two half-size tables, loaded word by word over a shift chain.
// Latency: outputs are combinational from addr, or one cycle through ce-gated flops when the mode selects registering.
// Backpressure: none; every cen=1 word is accepted, gaps between words are allowed, outputs read 0 until a load completes.
module fracturable_lut #(
  parameter  int INPUTS       = 4,
  parameter  int CONFIG_WIDTH = 4,
  localparam int MEM_SIZE     = 2**INPUTS,
  localparam int NWORDS       = MEM_SIZE / CONFIG_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cen,
  input  logic [CONFIG_WIDTH-1:0] config_in,
  input  logic                    ce,
  input  logic [INPUTS-1:0]       addr,
  output logic                    out0,
  output logic                    out1,
  output logic                    config_done
);

  localparam int CHAIN_W = NWORDS * CONFIG_WIDTH;
  localparam int CNT_W   = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHAIN_W-1:0]  chain_q, chain_d;
  logic [2:0]          mode_q, mode_d;
  logic                config_done_q, config_done_d;
  logic                out0_q, out0_d;
  logic                out1_q, out1_d;

  logic [MEM_SIZE-1:0] mem;
  logic                frac;
  logic [INPUTS-1:0]   idx0;
  logic [INPUTS-1:0]   idx1;
  logic                lut0;
  logic                lut1;

  // Config chain: new word enters at the top, so the first word ends up at the bottom after a full load.
  always_comb begin
    chain_d = chain_q;
    if (cen) begin
      chain_d = {config_in, chain_q[CHAIN_W-1:CONFIG_WIDTH]};
    end
  end

  // Load sequencer: counts accepted words; the mode is snapshotted on the completing word so a
  // reload in progress keeps the previous register/fracture selection until it finishes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (cen) begin
          state_d = LOAD;
          cnt_d   = CNT_W'(1);
        end
      end
      LOAD: begin
        if (cen) begin
          if (cnt_q == CNT_W'(NWORDS - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
            mode_d  = config_in[2:0];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (cen) begin
          state_d = LOAD;
          cnt_d   = CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    config_done_d = (state_d == DONE);
  end

  // Table read: fractured mode splits the table into lower/upper halves sharing the low address bits.
  always_comb begin
    mem  = chain_q[MEM_SIZE-1:0];
    frac = mode_q[0];
    idx0 = frac ? {1'b0, addr[INPUTS-2:0]} : addr;
    idx1 = {1'b1, addr[INPUTS-2:0]};
    lut0 = config_done_q & mem[idx0];
    lut1 = config_done_q & frac & mem[idx1];
  end

  // Output flops track the LUT on every ce edge regardless of mode, so a mode switch exposes a defined value.
  always_comb begin
    out0_d = out0_q;
    out1_d = out1_q;
    if (ce) begin
      out0_d = lut0;
      out1_d = lut1;
    end
  end

  // State register with synchronous active-low reset taking priority over cen and ce.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      chain_q       <= '0;
      mode_q        <= '0;
      config_done_q <= 1'b0;
      out0_q        <= 1'b0;
      out1_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      chain_q       <= chain_d;
      mode_q        <= mode_d;
      config_done_q <= config_done_d;
      out0_q        <= out0_d;
      out1_q        <= out1_d;
    end
  end

  assign out0        = mode_q[1] ? out0_q : lut0;
  assign out1        = mode_q[2] ? out1_q : lut1;
  assign config_done = config_done_q;

endmodule

// File: tb/tb_fracturable_lut.sv
module tb_fracturable_lut;

  logic       clk;
  logic       rst_n;
  logic       cen;
  logic [3:0] config_in;
  logic       ce;
  logic [3:0] addr;
  logic       out0;
  logic       out1;
  logic       config_done;

  int errors = 0;
  int checks = 0;

  fracturable_lut #(.INPUTS(4), .CONFIG_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .config_in  (config_in),
    .ce         (ce),
    .addr       (addr),
    .out0       (out0),
    .out1       (out1),
    .config_done(config_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       cen;
    logic [3:0] cfg;
    logic       ce;
    logic [3:0] addr;
    logic       e0;
    logic       e1;
    logic       ed;
  } vec_t;

  vec_t tbl[$];

  // Reference model: words collected per load; table and mode published only when five words arrive.
  logic [3:0]  m_words[$];
  bit          m_done;
  logic [15:0] m_mem;
  logic [2:0]  m_mode;
  logic        m_f0;
  logic        m_f1;

  function automatic logic m_lut0(input logic [3:0] a);
    int idx;
    idx = m_mode[0] ? (int'(a) % 8) : int'(a);
    return m_done ? m_mem[idx] : 1'b0;
  endfunction

  function automatic logic m_lut1(input logic [3:0] a);
    int idx;
    idx = 8 + (int'(a) % 8);
    return (m_done && m_mode[0]) ? m_mem[idx] : 1'b0;
  endfunction

  task automatic model_step(input logic r, input logic c, input logic [3:0] w, input logic e, input logic [3:0] a);
    logic l0;
    logic l1;
    l0 = m_lut0(a);
    l1 = m_lut1(a);
    if (r) begin
      m_words.delete();
      m_done = 0;
      m_mem  = '0;
      m_mode = '0;
      m_f0   = 1'b0;
      m_f1   = 1'b0;
    end else begin
      if (e) begin
        m_f0 = l0;
        m_f1 = l1;
      end
      if (c) begin
        m_done = 0;
        m_words.push_back(w);
        if (m_words.size() == 5) begin
          m_mem  = {m_words[3], m_words[2], m_words[1], m_words[0]};
          m_mode = m_words[4][2:0];
          m_done = 1;
          m_words.delete();
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic [3:0] w, input logic e, input logic [3:0] a);
    rst_n     = ~r;
    cen       = c;
    config_in = w;
    ce        = e;
    addr      = a;
    #1;
  endtask

  task automatic tick(input logic r, input logic c, input logic [3:0] w, input logic e, input logic [3:0] a);
    model_step(r, c, w, e, a);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic c, input logic [3:0] w, input logic e, input logic [3:0] a,
                     input logic e0, input logic e1, input logic ed);
    vec_t v;
    v.rst = r; v.cen = c; v.cfg = w; v.ce = e; v.addr = a;
    v.e0 = e0; v.e1 = e1; v.ed = ed;
    tbl.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b0; config_in = '0; ce = 1'b0; addr = '0;
    m_done = 0; m_mem = '0; m_mode = '0; m_f0 = 1'b0; m_f1 = 1'b0;

    // rst, cen, cfg, ce, addr, exp out0, out1, config_done (checked before the row's edge)
    add(0,0,4'h0,0,4'd0,  0,0,0);   // reset state
    add(0,1,4'h8,0,4'd3,  0,0,0);   // basic load
    add(0,1,4'h0,0,4'd3,  0,0,0);
    add(0,1,4'h0,0,4'd3,  0,0,0);
    add(0,1,4'h0,0,4'd3,  0,0,0);
    add(0,1,4'h0,0,4'd3,  0,0,0);
    add(0,0,4'h0,0,4'd3,  1,0,1);
    add(0,0,4'h0,0,4'd2,  0,0,1);
    add(0,1,4'h1,0,4'd3,  1,0,1);   // reconfig: old table still visible before the edge
    add(0,1,4'h0,0,4'd3,  0,0,0);   // done dropped, outputs forced 0
    add(0,1,4'h0,0,4'd3,  0,0,0);
    add(0,1,4'h8,0,4'd3,  0,0,0);
    add(0,1,4'h1,0,4'd3,  0,0,0);
    add(0,0,4'h0,0,4'd0,  1,0,1);   // fractured reads
    add(0,0,4'h0,0,4'd15, 0,1,1);
    add(0,0,4'h0,0,4'd8,  1,0,1);
    add(0,1,4'hF,1,4'd0,  1,0,1);   // registered output load
    add(0,1,4'hF,1,4'd0,  0,0,0);
    add(0,1,4'hF,1,4'd0,  0,0,0);
    add(0,1,4'hF,1,4'd0,  0,0,0);
    add(0,1,4'h2,1,4'd0,  0,0,0);
    add(0,0,4'h0,1,4'd0,  0,0,1);   // flop still holds pre-done 0
    add(0,0,4'h0,0,4'd0,  1,0,1);   // one edge later: 1
    add(0,1,4'h0,0,4'd0,  1,0,1);   // zero reload, ce=0
    add(0,1,4'h0,0,4'd0,  1,0,0);
    add(0,1,4'h0,0,4'd0,  1,0,0);
    add(0,1,4'h0,0,4'd0,  1,0,0);
    add(0,0,4'h0,1,4'd0,  1,0,0);   // ce edge mid-load loads gated 0
    add(0,0,4'h0,0,4'd0,  0,0,0);
    add(0,1,4'h0,0,4'd0,  0,0,0);
    add(0,0,4'h0,0,4'd0,  0,0,1);
    add(0,1,4'hF,0,4'd0,  0,0,1);   // gapped partial load
    add(0,0,4'h0,0,4'd0,  0,0,0);
    add(0,1,4'hF,0,4'd0,  0,0,0);
    add(0,0,4'h0,0,4'd0,  0,0,0);
    add(0,1,4'hF,0,4'd0,  0,0,0);
    add(1,1,4'hF,1,4'd0,  0,0,0);   // reset beats cen/ce
    add(0,1,4'h8,0,4'd3,  0,0,0);   // fresh load after reset
    add(0,1,4'h0,0,4'd3,  0,0,0);
    add(0,1,4'h0,0,4'd3,  0,0,0);
    add(0,1,4'h0,0,4'd3,  0,0,0);
    add(0,1,4'h0,0,4'd3,  0,0,0);
    add(0,0,4'h0,0,4'd3,  1,0,1);
    add(0,0,4'h0,0,4'd2,  0,0,1);

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 4'h0, 0, 4'd0);
      tick(1, 0, 4'h0, 0, 4'd0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].cen, tbl[i].cfg, tbl[i].ce, tbl[i].addr);
      chk($sformatf("vec%0d.out0", i), out0, tbl[i].e0);
      chk($sformatf("vec%0d.out1", i), out1, tbl[i].e1);
      chk($sformatf("vec%0d.config_done", i), config_done, tbl[i].ed);
      tick(tbl[i].rst, tbl[i].cen, tbl[i].cfg, tbl[i].ce, tbl[i].addr);
    end

    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic       c;
      logic [3:0] w;
      logic       e;
      logic [3:0] a;
      r = ($urandom_range(0, 249) == 0);
      c = ((i % 40) < 14) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 11) == 0);
      w = 4'($urandom_range(0, 15));
      e = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      drive(r, c, w, e, a);
      chk($sformatf("rnd%0d.out0", i), out0, m_mode[1] ? m_f0 : m_lut0(a));
      chk($sformatf("rnd%0d.out1", i), out1, m_mode[2] ? m_f1 : m_lut1(a));
      chk($sformatf("rnd%0d.config_done", i), config_done, m_done);
      tick(r, c, w, e, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fracturable_lut.md
FRACTURABLE_LUT -- requirements
Module: fracturable_lut

Interface
REQ-001 SHALL have parameter INPUTS, default 4, meaning LUT address width; legal range 3..6.
REQ-002 SHALL have parameter CONFIG_WIDTH, default 4, meaning config word width; it is at least 3 and divides 2**INPUTS.
REQ-003 SHALL have derived parameter MEM_SIZE = 2**INPUTS (truth-table bits) and NWORDS = MEM_SIZE/CONFIG_WIDTH + 1 (config words per load).
REQ-004 SHALL have port clk, input, 1, the single clock for configuration and operation.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port cen, input, 1, config word valid.
REQ-007 SHALL have port config_in, input, CONFIG_WIDTH, config word, sampled when cen=1.
REQ-008 SHALL have port ce, input, 1, clock enable for the output registers.
REQ-009 SHALL have port addr, input, INPUTS, LUT address.
REQ-010 SHALL have port out0, output, 1, primary LUT output.
REQ-011 SHALL have port out1, output, 1, secondary output; 0 in non-fractured mode.
REQ-012 SHALL have port config_done, output, 1, high when a full configuration is held.

Function
REQ-013 SHALL hold a config chain of NWORDS*CONFIG_WIDTH bits that updates only on clk edges with cen=1: chain <= {config_in, chain[top:CONFIG_WIDTH]}.
REQ-014 SHALL map chain bits after a complete load as follows: the first word loaded is mem[CONFIG_WIDTH-1:0], ascending; the last word loaded is the mode word.
REQ-015 SHALL decode mode word bit0 = frac, bit1 = reg0, bit2 = reg1, and SHALL ignore higher bits.
REQ-016 SHALL implement FSM states IDLE, LOAD, DONE with a word counter of width clog2(NWORDS+1).
REQ-017 SHALL transition IDLE->LOAD on cen=1 (count=1), or straight to DONE if NWORDS=1 is ever legal (it is not).
REQ-018 SHALL handle LOAD as follows: cen=1 increments count; when the accepted word makes count=NWORDS, go to DONE and clear count; cen=0 holds state and count (gaps allowed).
REQ-019 SHALL handle DONE as follows: cen=1 starts reconfiguration, goes to LOAD with count=1, and drops config_done in the same edge.
REQ-020 SHALL make config_done a register that is 1 exactly while in DONE, asserting on the edge that accepts word NWORDS.
REQ-021 SHALL read combinationally in non-fractured mode (frac=0): lut0 = mem[addr], lut1 = 0.
REQ-022 SHALL read combinationally in fractured mode (frac=1), with a = addr[INPUTS-2:0]: lut0 = mem[a] (lower half) and lut1 = mem[MEM_SIZE/2 + a] (upper half); addr[INPUTS-1] is ignored.
REQ-023 SHALL force lut0 and lut1 to 0 while config_done=0.
REQ-024 SHALL drive out0 = lut0 combinationally (latency 0) when reg0=0, and out1 = lut1 when reg1=0.
REQ-025 SHALL, when regN=1, drive outN from a flop that loads lutN on edges with ce=1 and holds otherwise (latency 1 cycle).
REQ-026 SHALL clock both output flops whenever ce=1, regardless of mode, so that switching reg bits by reconfiguration exposes a defined value.
REQ-027 SHALL, when cen=1 and ce=1 arrive on the same edge in DONE, sample lutN by the output flop from the pre-edge configuration; that flop is then 0 from the next ce edge while config_done=0.
REQ-028 SHALL give a partially loaded chain no functional effect: outputs stay 0 until DONE.

Reset
REQ-029 SHALL, with rst_n=0 at a clk edge, clear the chain (mem and mode) to 0, the FSM to IDLE, count to 0, config_done to 0, and both output flops to 0.
REQ-030 SHALL give reset priority over cen and ce; reset during LOAD discards the partial load.
REQ-031 SHALL, after reset, hold out0=0, out1=0, config_done=0 until a full load completes.

Verification (INPUTS=4, CONFIG_WIDTH=4, NWORDS=5)
REQ-032 SHALL cover basic load: words 0x8,0x0,0x0,0x0,0x0 on five consecutive cen cycles -> config_done rises on the 5th edge; mem=16'h0008; addr=3 -> out0=1, addr=2 -> out0=0, out1=0.
REQ-033 SHALL cover fracture: words 0x1,0x0,0x0,0x8,0x1 -> mem=16'h8001; addr=4'b0000 -> out0=1,out1=0; addr=4'b1111 -> out0=0,out1=1; addr=4'b1000 -> out0=1.
REQ-034 SHALL cover registered output: load 0xF,0xF,0xF,0xF,0x2, ce=1 -> out0 goes 1 one edge after config_done; hold ce=0 and reload all-zero words -> out0 stays 1 until ce=1, then 0.
REQ-035 SHALL cover gapped load with mid-load reset: 3 words with cen idle cycles between, then rst_n=0 for one edge -> config_done=0, outputs 0; a fresh 5-word load succeeds normally.
REQ-036 SHALL cover reconfiguration: in DONE, first word of a new load -> config_done=0 and out0=out1=0 on the next cycle until the 5th new word.
